keycode_display_sequencer: RTL and testbench
============================================

// Module: keycode_display_sequencer
// PURPOSE
//   Sequences PS/2 scan-code bytes into a 4-entry history of released keys and
//   time-multiplexes that history onto a 4-digit display. It sits between the
//   PS/2 byte receiver (valid_code strobe + scan_code_in) and the 7-segment
//   decoder (code_to_display + seg_en).
//   Break (F0) and extended (E0) prefixes are decoded by an FSM.
//   A refresh prescaler schedules digit slots.
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles per digit slot; legal range >=1
// PORTS
//   clk              in   1  system clock, rising edge
//   rst              in   1  reset, asynchronous, active-low
//   valid_code       in   1  one-cycle strobe: scan_code_in holds a new byte
//   scan_code_in     in   8  received scan-code byte
//   clear            in   1  synchronous history clear, active-high
//   code_to_display  out  8  code of the currently scanned digit
//   seg_en           out  4  digit enable, active-low one-hot
//   ext_flag         out  1  currently scanned entry is an extended key
//   new_key          out  1  one-cycle pulse after each history push
// BEHAVIOUR
//   Reset: async, takes effect immediately, including mid-frame or mid-prefix.
//     State=IDLE, history all {ext=0,code=00}, digit idx=0, prescaler=0,
//     seg_en=4'b1110, code_to_display=8'h00, ext_flag=0, new_key=0.
//   FSM (advances only on clk edges with valid_code=1; otherwise holds):
//     IDLE:      F0->BREAK; E0->EXT; any other byte (make code) ignored.
//     BREAK:     F0 -> stay, no push; E0 -> stay, no push;
//                other byte -> push {0,byte}, ->IDLE.
//     EXT:       F0->EXT_BREAK; any other byte -> IDLE (extended make dropped).
//     EXT_BREAK: F0/E0 -> stay, no push; other byte -> push {1,byte}, ->IDLE.
//   History push: entry3<=entry2, entry2<=entry1, entry1<=entry0,
//     entry0<=new. The old entry3 is discarded. There is no full condition.
//   new_key: registered; high exactly in the cycle after the push edge.
//   clear=1: at that edge history<=all 0, FSM<=IDLE, no push, new_key=0.
//     clear wins over a simultaneous valid_code.
//   Prescaler: counts 0..REFRESH_DIV-1 and wraps.
//     On terminal count, idx<=idx+1 mod 4 (3 wraps to 0).
//     With REFRESH_DIV=1, idx advances every cycle.
//   Display outputs are combinational from the registered idx and history:
//     idx0->1110/entry0, idx1->1101/entry1, idx2->1011/entry2,
//     idx3->0111/entry3.
//     ext_flag = ext bit of the selected entry.
//     A push is visible on code_to_display in the cycle after the push edge.
//   Empty entries display 8'h00; no blanking.
//   Prescaler and idx run independently of FSM, clear and pushes.
// CONFIGURATION
//   KBD_EXT_CODE_EN defined: EXT/EXT_BREAK states present as above; ext_flag live.
//   KBD_EXT_CODE_EN undefined: no EXT states.
//     E0 in IDLE is ignored; E0 in BREAK is pushed as {0,E0}.
//     ext_flag tied 0; ext bits not stored.
// TESTING (REFRESH_DIV=4 unless stated)
//   1 Assert rst mid-frame -> same cycle: seg_en=1110, code_to_display=00,
//     new_key=0, ext_flag=0.
//   2 Bytes 1C,F0,1C -> single new_key pulse; entry0=1C; digit0 shows 1C;
//     the make code alone causes no push.
//   3 Releases 16,1E,26,25,2E -> seg_en cycles 1110,1101,1011,0111,1110,
//     one step every 4 clk; codes shown 2E,25,26,1E; 16 dropped.
//   4 E0,F0,75: with KBD_EXT_CODE_EN -> entry0=75, ext_flag=1 at idx0;
//     without it -> entry0=75, ext_flag=0.
//   5 F0,F0,29 -> exactly one push (29), one new_key pulse.
//   6 After pushes, clear=1 coincident with break data byte -> history all 00,
//     no new_key, next F0 accepted from IDLE.

Source files
------------

// File: rtl/keycode_display_sequencer.sv
// keycode_display_sequencer: decodes PS/2 break sequences into a 4-deep released-key history
// and scans that history onto a 4-digit display. Optional macro KBD_EXT_CODE_EN adds E0 decoding.
module keycode_display_sequencer #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_code,
    input  logic [7:0] scan_code_in,
    input  logic       clear,
    output logic [7:0] code_to_display,
    output logic [3:0] seg_en,
    output logic       ext_flag,
    output logic       new_key
);
    localparam logic [7:0] BREAK_CODE = 8'hF0;
`ifdef KBD_EXT_CODE_EN
    localparam logic [7:0] EXT_CODE   = 8'hE0;
`endif
    localparam int unsigned   PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

    state_t        state_q, state_d;
    logic          push;
    logic [7:0]    code_q [4];
    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic          new_key_q;
`ifdef KBD_EXT_CODE_EN
    logic          push_ext;
    logic [3:0]    ext_q;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        push    = 1'b0;
`ifdef KBD_EXT_CODE_EN
        push_ext = 1'b0;
`endif
        if (clear) begin
            state_d = S_IDLE;
        end else if (valid_code) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code_in == BREAK_CODE) state_d = S_BREAK;
`ifdef KBD_EXT_CODE_EN
                    else if (scan_code_in == EXT_CODE) state_d = S_EXT;
`endif
                end
                S_BREAK: begin
`ifdef KBD_EXT_CODE_EN
                    if (scan_code_in != BREAK_CODE && scan_code_in != EXT_CODE) begin
`else
                    if (scan_code_in != BREAK_CODE) begin
`endif
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
`ifdef KBD_EXT_CODE_EN
                // An extended make code is dropped; only E0 F0 xx records a key.
                S_EXT: state_d = (scan_code_in == BREAK_CODE) ? S_EXT_BREAK : S_IDLE;
                S_EXT_BREAK: begin
                    if (scan_code_in != BREAK_CODE && scan_code_in != EXT_CODE) begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            new_key_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            new_key_q <= push;
        end
    end

    // NOTE: the history is four plain flops, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) code_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) code_q[i] <= '0;
        end else if (push) begin
            code_q[3] <= code_q[2];
            code_q[2] <= code_q[1];
            code_q[1] <= code_q[0];
            code_q[0] <= scan_code_in;
        end
    end

`ifdef KBD_EXT_CODE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q <= '0;
        end else if (clear) begin
            ext_q <= '0;
        end else if (push) begin
            ext_q <= {ext_q[2:0], push_ext};
        end
    end
`endif

    // Digit scan runs free of the decoder, clear and pushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign code_to_display = code_q[idx_q];
    assign seg_en          = ~(4'b0001 << idx_q);
    assign new_key         = new_key_q;
`ifdef KBD_EXT_CODE_EN
    assign ext_flag        = ext_q[idx_q];
`else
    assign ext_flag        = 1'b0;
`endif

endmodule

// File: tb/tb_keycode_display_sequencer.sv
// Bench for keycode_display_sequencer: flag-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized byte streams.
`timescale 1ns/1ps
module tb_keycode_display_sequencer;
    localparam int unsigned REFRESH_DIV = 4;
`ifdef KBD_EXT_CODE_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_code = 1'b0;
    logic [7:0] scan_code_in = 8'h00;
    logic       clear = 1'b0;
    logic [7:0] code_to_display;
    logic [3:0] seg_en;
    logic       ext_flag;
    logic       new_key;

    int n_total = 0;
    int n_bad   = 0;
    int nk_count = 0;

    keycode_display_sequencer #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst(rst), .valid_code(valid_code), .scan_code_in(scan_code_in),
        .clear(clear), .code_to_display(code_to_display), .seg_en(seg_en),
        .ext_flag(ext_flag), .new_key(new_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: released-key list plus "break seen" / "extended seen" flags.
    logic [7:0] m_code [4];
    logic       m_ext  [4];
    bit         m_brk, m_xp, m_new;
    int         m_edges;
    logic [3:0] seg_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin m_code[i] = 8'h00; m_ext[i] = 1'b0; end
            m_brk = 0; m_xp = 0; m_new = 0; m_edges = 0;
        end else begin
            m_edges++;
            m_new = 0;
            if (clear) begin
                for (int i = 0; i < 4; i++) begin m_code[i] = 8'h00; m_ext[i] = 1'b0; end
                m_brk = 0; m_xp = 0;
            end else if (valid_code) begin
                if (scan_code_in == 8'hF0) begin
                    m_brk = 1;
                end else if (scan_code_in == 8'hE0 && EXT_EN) begin
                    if (!m_brk) m_xp = !m_xp;
                end else begin
                    if (m_brk) begin
                        for (int i = 3; i > 0; i--) begin m_code[i] = m_code[i-1]; m_ext[i] = m_ext[i-1]; end
                        m_code[0] = scan_code_in;
                        m_ext[0]  = m_xp;
                        m_new = 1;
                        m_brk = 0;
                    end
                    m_xp = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int idx;
        if (rst) begin
            idx = (m_edges / REFRESH_DIV) % 4;
            check("seg_en", 32'(seg_en), 32'(seg_tbl[idx]));
            check("code_to_display", 32'(code_to_display), 32'(m_code[idx]));
            check("ext_flag", 32'(ext_flag), 32'(m_ext[idx]));
            check("new_key", 32'(new_key), 32'(m_new));
            if (new_key) nk_count++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #2;
        valid_code = 1'b1; scan_code_in = b;
        @(posedge clk); #2;
        valid_code = 1'b0;
    endtask

    task automatic wait_seg(input logic [3:0] target);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (seg_en == target) break;
        end
        if (k == 40) check("wait_seg_timeout", 32'(seg_en), 32'(target));
    endtask

    task automatic check_digit(input string name, input logic [3:0] target, input logic [7:0] code);
        wait_seg(target);
        check(name, 32'(code_to_display), 32'(code));
    endtask

    task automatic check_rotation(input logic [7:0] e0, input logic [7:0] e1,
                                  input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp [4];
        logic [3:0] prev;
        int k;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        @(negedge clk);
        prev = seg_en;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (seg_en == 4'b1110 && prev == 4'b0111) break;
            prev = seg_en;
        end
        if (k == 40) check("rotation_timeout", 32'(seg_en), 32'h0);
        for (int s = 0; s < 5; s++) begin
            check("rotation_seg", 32'(seg_en), 32'(seg_tbl[s % 4]));
            check("rotation_code", 32'(code_to_display), 32'(exp[s % 4]));
            repeat (REFRESH_DIV) @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("rst_seg_en", 32'(seg_en), 32'h0000000E);
        check("rst_code", 32'(code_to_display), 32'h00);
        check("rst_new_key", 32'(new_key), 32'h0);
        check("rst_ext_flag", 32'(ext_flag), 32'h0);
        idle(2);
        @(posedge clk); #3;
        rst = 1'b1;
    endtask

    initial begin
        int n0;
        logic [7:0] b;
        #2;
        check("reset_seg_en", 32'(seg_en), 32'h0000000E);
        check("reset_code", 32'(code_to_display), 32'h00);
        @(posedge clk); #3;
        rst = 1'b1;

        // make code alone, then a release
        n0 = nk_count;
        send(8'h1C); idle(3);
        check("make_no_push", 32'(nk_count - n0), 32'd0);
        send(8'hF0); send(8'h1C); idle(3);
        check("release_one_pulse", 32'(nk_count - n0), 32'd1);
        check_digit("digit0_1C", 4'b1110, 8'h1C);

        // five releases: oldest two drop off
        foreach (seg_tbl[i]) ;
        send(8'hF0); send(8'h16);
        send(8'hF0); send(8'h1E);
        send(8'hF0); send(8'h26);
        send(8'hF0); send(8'h25);
        send(8'hF0); send(8'h2E);
        check_rotation(8'h2E, 8'h25, 8'h26, 8'h1E);

        // extended release
        send(8'hE0); send(8'hF0); send(8'h75);
        wait_seg(4'b1110);
        check("ext_code", 32'(code_to_display), 32'h75);
        check("ext_flag_idx0", 32'(ext_flag), 32'(EXT_EN));

        // doubled break prefix
        n0 = nk_count;
        send(8'hF0); send(8'hF0); send(8'h29); idle(3);
        check("double_f0_one_pulse", 32'(nk_count - n0), 32'd1);
        check_digit("double_f0_digit0", 4'b1110, 8'h29);
        check_digit("double_f0_digit1", 4'b1101, 8'h75);

        // clear coincident with a break data byte
        n0 = nk_count;
        send(8'hF0);
        @(posedge clk); #2;
        valid_code = 1'b1; scan_code_in = 8'h5A; clear = 1'b1;
        @(posedge clk); #2;
        valid_code = 1'b0; clear = 1'b0;
        idle(3);
        check("clear_no_pulse", 32'(nk_count - n0), 32'd0);
        check_rotation(8'h00, 8'h00, 8'h00, 8'h00);
        send(8'hF0); send(8'h44); idle(3);
        check("after_clear_pulse", 32'(nk_count - n0), 32'd1);
        check_digit("after_clear_digit0", 4'b1110, 8'h44);

        // asynchronous reset mid-frame with a non-empty history
        pulse_reset();

        // randomized streams
        for (int i = 0; i < 1500; i++) begin
            int sel;
            sel = $urandom_range(0, 11);
            if (i == 700) pulse_reset();
            if (sel <= 3) b = 8'hF0;
            else if (sel <= 5) b = 8'hE0;
            else b = 8'($urandom_range(0, 255));
            if (sel == 11) begin
                @(posedge clk); #2;
                clear = 1'b1;
                valid_code = 1'($urandom_range(0, 1)); scan_code_in = b;
                @(posedge clk); #2;
                clear = 1'b0; valid_code = 1'b0;
            end else begin
                send(b);
            end
            idle($urandom_range(0, 2));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
